// File: rtl/imm_extend_pipe.sv
// Purpose : MIPS immediate extension (sign / zero / upper / branch) into a 2-entry elastic buffer.
// Latency : 1 cycle from accept to out_imm when the buffer is empty; 1 transfer/cycle sustained.
// Backpr. : absorbs 2 results with out_ready low; in_ready comes from registered count only.
// Option  : `define IMM_EXT_BRANCH_EN makes mode 11 sign-extend then shift left 2; otherwise mode 11 == mode 00.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm
);

    localparam int S = OUT_W - IN_W;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_ext;
`ifdef IMM_EXT_BRANCH_EN
    logic [OUT_W-1:0] w_branch;
`endif

    // Buffer state: two entries, 1-bit pointers, occupancy 0..2.
    logic [1:0][OUT_W-1:0] r_mem;
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_count;
    logic [OUT_W-1:0]      r_out_imm;

    logic                  w_push;
    logic                  w_pop;
    logic [1:0][OUT_W-1:0] w_mem_nxt;
    logic                  w_head_nxt;
    logic                  w_tail_nxt;
    logic [1:0]            w_count_nxt;

    assign w_sext  = {{S{in_imm[IN_W-1]}}, in_imm};
    assign w_zext  = {{S{1'b0}}, in_imm};
    assign w_upper = {in_imm, {S{1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
    // The two bits shifted out of the top are dropped.
    assign w_branch = {w_sext[OUT_W-3:0], 2'b00};
`endif

    // Select the extended operand from the mode code.
    always_comb begin
        w_ext = w_sext;
        case (in_mode)
            2'b00:   w_ext = w_sext;
            2'b01:   w_ext = w_zext;
            2'b10:   w_ext = w_upper;
`ifdef IMM_EXT_BRANCH_EN
            2'b11:   w_ext = w_branch;
`else
            2'b11:   w_ext = w_sext;
`endif
            default: w_ext = w_sext;
        endcase
    end

    // in_ready depends only on the registered count and reset, never on out_ready.
    assign in_ready  = (r_count != 2'd2) && !rst;
    assign out_valid = (r_count != 2'd0);
    assign out_imm   = r_out_imm;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Next buffer state: write at tail on push, advance head on pop.
    always_comb begin
        w_mem_nxt   = r_mem;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_push) begin
            w_mem_nxt[r_tail] = w_ext;
            w_tail_nxt        = ~r_tail;
        end
        if (w_pop) begin
            w_head_nxt = ~r_head;
        end
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Registered state; out_imm tracks the next head entry and holds when the buffer drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem     <= '0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_count   <= 2'd0;
            r_out_imm <= '0;
        end else begin
            r_mem   <= w_mem_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            if (w_count_nxt != 2'd0) begin
                r_out_imm <= w_mem_nxt[w_head_nxt];
            end
        end
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension stage for the MIPS datapath. It takes an IN_W-bit instruction immediate plus a mode code and produces an OUT_W-bit operand: sign-extended, zero-extended, upper-loaded (LUI), or branch-offset (sign-extend then shift left 2). A registered output and a 2-entry elastic buffer with valid/ready handshakes on both sides let it sit between decode and the ALU-operand mux without adding a combinational path.

## Interface
- IN_W, 16, immediate input width; must be at least 2.
- OUT_W, 32, extended output width; must be at least IN_W+2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  upstream has an immediate.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
- out_valid  output  1  out_imm holds a valid result.
- out_ready  input  1  downstream accepts.
- out_imm  output  OUT_W  extended result at the buffer head.

## Operation
- Accept: the stage accepts a transfer when in_valid && in_ready at a rising clk edge. A pop occurs when out_valid && out_ready.
- Modes (S = OUT_W-IN_W):
  - 00: {S copies of in_imm[IN_W-1], in_imm}.
  - 01: {S zeros, in_imm}.
  - 10: in_imm << S, with the low S bits zero.
  - 11: sign-extend, then shift left 2. The top two bits shifted out are discarded.
- Extension is computed combinationally at the input. The result is written into the buffer, so no unregistered path reaches out_imm.
- Buffer: 2 entries, head/tail pointers of 1 bit each, occupancy count 0..2.
  - out_valid = (count != 0).
  - out_imm = entry[head].
  - in_ready = (count != 2) && !rst.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Full (count==2): in_ready=0. A pop in this cycle makes in_ready=1 on the next cycle, not the same one.
- Empty (count==0): out_valid=0 and out_imm holds its last value. No pop can occur.
- Pointers wrap modulo 2.
- Reset mid-operation: all buffered entries are dropped immediately. The stage does not accept on the edge where rst deasserts if rst is still high at that edge.
- in_imm/in_mode are sampled only on accept. Changing them while in_ready=0 has no effect.

## Timing
- Reset values: out_valid=0, out_imm=0, in_ready=0 while rst=1, count=0, head=tail=0. in_ready is 1 from the first cycle after rst deasserts.
- Latency: a value accepted at edge N is on out_imm with out_valid=1 after edge N when the buffer was empty.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- With out_ready=0, the stage absorbs 2 transfers, then stalls upstream.
- out_imm/out_valid must stay stable while out_valid=1 && out_ready=0.

## Configuration
- IMM_EXT_BRANCH_EN defined:
  - Mode 11 performs sign-extend then shift left 2, as above.
- IMM_EXT_BRANCH_EN undefined:
  - Mode 11 is treated exactly as mode 00 (plain sign extension) and no shifter logic is synthesised.
  - Modes 00/01/10 are unaffected.

## Test plan
- Reset with rst=1 for 3 cycles -> out_valid=0, out_imm=0, in_ready=0. in_ready=1 one cycle after release.
- Defaults, out_ready=1, send 0x8001/mode 00, 0x8001/mode 01, 0x1234/mode 10 back-to-back -> out_imm 0xFFFF8001, 0x00008001, 0x12340000 on consecutive cycles, one cycle after each accept.
- Mode 11 with 0xFFFF:
  - With IMM_EXT_BRANCH_EN -> 0xFFFFFFFC.
  - Without it -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 and offer 3 values (0x0001, 0x0002, 0x0003, mode 00):
  - Only 2 are accepted and in_ready=0.
  - out_imm is held at 0x00000001.
  - After out_ready=1, outputs are 1, 2, 3 in order, with no loss or duplication.
- Simultaneous push/pop at count=1 -> count stays 1, order preserved. Repeat across 4 transfers to exercise pointer wrap.
- Assert rst while count=2 -> out_valid=0 immediately. After release, the first new value 0x7FFF/mode 00 appears as 0x00007FFF with no stale data.
